// File: rtl/ibuf.sv
// Pad input conditioning: raw pass-through plus a synchronised, edge-detected level per bit.
// Optional per-bit stability filter is built when IBUF_FILTER_EN is defined.
module ibuf #(
    parameter int WIDTH         = 1,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] O,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("ibuf: WIDTH must be 1..32");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("ibuf: SYNC_STAGES must be >= 2");
    end
    if (FILTER_CYCLES < 1) begin : g_bad_filter
        $error("ibuf: FILTER_CYCLES must be >= 1");
    end

    assign O = I;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= I;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef IBUF_FILTER_EN
    localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q [WIDTH];

    // Any reversal of s before the count completes clears the count: no partial credit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level <= '0;
            for (int b = 0; b < WIDTH; b++) begin
                cnt_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < WIDTH; b++) begin
                if (s[b] == level[b]) begin
                    cnt_q[b] <= '0;
                end else if (cnt_q[b] == CNT_LAST) begin
                    level[b] <= s[b];
                    cnt_q[b] <= '0;
                end else begin
                    cnt_q[b] <= cnt_q[b] + CNT_W'(1);
                end
            end
        end
    end
`else
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level <= '0;
        end else begin
            level <= s;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev <= '0;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;

endmodule

// File: tb/tb_ibuf.sv
// Directed bench for ibuf (WIDTH=8, SYNC_STAGES=2, FILTER_CYCLES=4); expectations
// follow the build selected by IBUF_FILTER_EN.
module tb_ibuf;

`ifdef IBUF_FILTER_EN
    localparam int LAT        = 6;
    localparam int GLITCH_W   = 3;
    localparam int GLITCH_EXP = 0;
`else
    localparam int LAT        = 3;
    localparam int GLITCH_W   = 1;
    localparam int GLITCH_EXP = 1;
`endif

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] I;
    logic [7:0] O;
    logic [7:0] level;
    logic [7:0] rise;
    logic [7:0] fall;

    int n_vec = 0;
    int n_err = 0;

    ibuf #(
        .WIDTH(8),
        .SYNC_STAGES(2),
        .FILTER_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .I(I),
        .O(O),
        .level(level),
        .rise(rise),
        .fall(fall)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle(input logic [7:0] v);
        I = v;
        repeat (12) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nrise;
        int nfall;

        // reset with I=1 held
        reset_n = 1'b0;
        I = 8'h01;
        repeat (3) tick();
        check("rst_level", level, 32'h0);
        check("rst_rise", rise, 32'h0);
        check("rst_fall", fall, 32'h0);
        check("rst_o", O, 32'h01);
        reset_n = 1'b1;
        nrise = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            nrise += int'(rise[0]);
            if (k == LAT) check("rst_rise_at_lat", rise[0], 1);
        end
        check("rst_rise_count", nrise, 1);

        // O pass-through
        I = 8'h3C;
        #1;
        check("o_pass_3c", O, 32'h3C);
        I = 8'hC3;
        #1;
        check("o_pass_c3", O, 32'hC3);

        // latency 0->1 and 1->0
        settle(8'h00);
        I = 8'h01;
        for (int k = 1; k <= LAT + 1; k++) begin
            tick();
            check($sformatf("lat_level_%0d", k), level[0], (k >= LAT));
            check($sformatf("lat_rise_%0d", k), rise[0], (k == LAT));
        end
        I = 8'h00;
        for (int k = 1; k <= LAT + 1; k++) begin
            tick();
            check($sformatf("lat_fall_level_%0d", k), level[0], (k < LAT));
            check($sformatf("lat_fall_%0d", k), fall[0], (k == LAT));
        end

        // short pulse: rejected with filter, passed through without
        settle(8'h00);
        nrise = 0;
        I = 8'h01;
        for (int k = 1; k <= 20; k++) begin
            if (k == GLITCH_W + 1) I = 8'h00;
            tick();
            nrise += int'(rise[0]);
        end
        check("glitch_rise_count", nrise, GLITCH_EXP);
        check("glitch_level_end", level[0], 0);

        // 4-clock pulse accepted in both builds
        nrise = 0;
        nfall = 0;
        I = 8'h01;
        for (int k = 1; k <= 20; k++) begin
            if (k == 5) I = 8'h00;
            tick();
            nrise += int'(rise[0]);
            nfall += int'(fall[0]);
        end
        check("pulse4_rise_count", nrise, 1);
        check("pulse4_fall_count", nfall, 1);

        // bit independence
        settle(8'h00);
        I = 8'hA5;
        for (int k = 1; k <= LAT + 1; k++) begin
            tick();
            if (k == LAT - 1) check("bits_level_pre", level, 32'h00);
            if (k == LAT) begin
                check("bits_rise", rise, 32'hA5);
                check("bits_level", level, 32'hA5);
            end
            if (k == LAT + 1) begin
                check("bits_rise_clr", rise, 32'h00);
                check("bits_level_hold", level, 32'hA5);
            end
        end
        I = 8'h5A;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (k == LAT) begin
                check("bits_fall2", fall, 32'hA5);
                check("bits_rise2", rise, 32'h5A);
                check("bits_level2", level, 32'h5A);
            end
        end

        // reset pulsed 2 clocks into a count
        settle(8'h00);
        I = 8'h01;
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        check("midrst_level", level, 32'h0);
        repeat (2) tick();
        check("midrst_level_held", level, 32'h0);
        reset_n = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            check($sformatf("midrst_level_%0d", k), level[0], (k >= LAT));
            if (k == LAT) check("midrst_rise", rise[0], 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
